// File: rtl/uart_log_pkg.sv
// uart_log_pkg: shared constants, state encoding and
// sizing helper for the UART hex logger.
package uart_log_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } log_state_t;

    // Characters printed per word: one per nibble, plus CR LF.
    function automatic int nchars(input int word_width,
                                  input int newline);
        return word_width / 4 + ((newline != 0) ? 2 : 0);
    endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// hex_nibble_to_ascii: one nibble to its uppercase
// ASCII hex digit.
module hex_nibble_to_ascii
    import uart_log_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // 0..9 map onto '0'..'9', 10..15 onto 'A'..'F'.
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'd0, nibble};
        end else begin
            ascii = ASCII_A + {4'd0, nibble - 4'd10};
        end
    end

endmodule

// File: rtl/uart_hex_logger.sv
// uart_hex_logger: prints accepted words as uppercase hex
// over the UART transmitter's stb/busy handshake.
module uart_hex_logger
    import uart_log_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int NEWLINE    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_stb,
    input  logic                  tx_busy,
    output logic                  active
);

    localparam int NCHARS = nchars(WORD_WIDTH, NEWLINE);
    localparam int CW     = $clog2(NCHARS + 1);

    localparam logic [CW-1:0] CNT_LOAD  = CW'(NCHARS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_CR    = CW'(2);
    localparam logic [CW-1:0] DIGIT_MIN = CW'((NEWLINE != 0) ? 3 : 1);

    log_state_t            state;
    logic [WORD_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic [7:0]            hex_char;
    logic [7:0]            cur_char;

    hex_nibble_to_ascii u_hex (
        .nibble (shreg[WORD_WIDTH-1 -: 4]),
        .ascii  (hex_char)
    );

    // Digits while nibbles remain, then CR and finally LF.
    always_comb begin
        cur_char = hex_char;
        if (cnt < DIGIT_MIN) begin
            cur_char = (cnt == CNT_CR) ? ASCII_CR : ASCII_LF;
        end
    end

    // Accept a word, then one stb per character, each
    // confirmed by the transmitter's busy rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            tx_stb  <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        cnt   <= CNT_LOAD;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_stb  <= 1'b1;
                        tx_data <= cur_char;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    tx_stb <= 1'b0;
                    if (tx_busy) begin
                        cnt   <= cnt - CNT_ONE;
                        shreg <= shreg << 4;
                        state <= (cnt == CNT_ONE) ? IDLE : SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign active   = !in_ready;

endmodule

// File: tb/tb_uart_hex_logger.sv
// tb_uart_hex_logger: three logger configurations, each
// driving a character-level transmitter model.
module tb_uart_hex_logger;

    localparam int FRAME = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] d0;
    logic [7:0]  d1;
    logic [3:0]  d2;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  tx_stb;
    logic [2:0]  active;
    logic [2:0]  tx_busy;
    logic [2:0]  hold;
    logic [2:0]  busy_q = 3'b000;
    logic [7:0]  txd [3];

    int       bcnt [3]     = '{0, 0, 0};
    int       stbcnt [3]   = '{0, 0, 0};
    logic [7:0] lat [3]    = '{8'h00, 8'h00, 8'h00};
    bit       lat_ok [3]   = '{0, 0, 0};
    bit       prev_stb [3] = '{0, 0, 0};

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    int n_checks = 0;
    int n_fail   = 0;

    assign tx_busy = busy_q | hold;

    uart_hex_logger #(.WORD_WIDTH(32), .NEWLINE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .tx_data(txd[0]), .tx_stb(tx_stb[0]),
        .tx_busy(tx_busy[0]), .active(active[0])
    );

    uart_hex_logger #(.WORD_WIDTH(8), .NEWLINE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .tx_data(txd[1]), .tx_stb(tx_stb[1]),
        .tx_busy(tx_busy[1]), .active(active[1])
    );

    uart_hex_logger #(.WORD_WIDTH(4), .NEWLINE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .tx_data(txd[2]), .tx_stb(tx_stb[2]),
        .tx_busy(tx_busy[2]), .active(active[2])
    );

    function automatic void check(input bit ok, input string name,
                                  input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic void push(input int i, input logic [7:0] b);
        case (i)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic void push_str(input int i, input string s, input bit nl);
        for (int k = 0; k < s.len(); k++) push(i, s[k]);
        if (nl) begin
            push(i, 8'h0D);
            push(i, 8'h0A);
        end
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qpop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    always @(negedge rst_n) begin
        for (int i = 0; i < 3; i++) lat_ok[i] = 0;
    end

    // Transmitter model, protocol checks and scoreboard monitor.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (tx_stb[i]) begin
                check(!prev_stb[i], "stb_back_to_back", 1, 0);
                check(!tx_busy[i], "stb_while_busy", tx_busy[i], 0);
                stbcnt[i]++;
            end
            prev_stb[i] = tx_stb[i];
            if (busy_q[i] && lat_ok[i])
                check(txd[i] == lat[i], "tx_data_stable", txd[i], lat[i]);
            if (tx_stb[i] && !tx_busy[i]) begin
                busy_q[i] <= 1'b1;
                bcnt[i]   <= FRAME - 1;
                lat[i]     = txd[i];
                lat_ok[i]  = 1;
                if (qsize(i) == 0) begin
                    check(0, "sb_unexpected_char", txd[i], 0);
                end else begin
                    logic [7:0] e;
                    e = qpop(i);
                    check(txd[i] == e, "sb_char", txd[i], e);
                end
            end else if (busy_q[i]) begin
                if (bcnt[i] == 0) busy_q[i] <= 1'b0;
                else bcnt[i] <= bcnt[i] - 1;
            end
        end
    end

    task automatic offer(input int i, input logic [31:0] w, input bit keep);
        int n;
        @(negedge clk);
        case (i)
            0:       d0 = w;
            1:       d1 = w[7:0];
            default: d2 = w[3:0];
        endcase
        in_valid[i] = 1'b1;
        n = 0;
        while (!in_ready[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(in_ready[i] == 1'b1, "accept_timeout", n, 0);
        @(posedge clk);
        #1;
        if (!keep) in_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (!(in_ready[i] && !busy_q[i]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(n < 3000, "idle_timeout", n, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_stbs(input int i, input int s, input int k);
        int n;
        n = 0;
        while (stbcnt[i] - s < k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(n < 3000, "stb_timeout", n, 0);
    endtask

    initial begin
        int s;
        int n;
        int bad;
        rst_n    = 1'b0;
        in_valid = 3'b000;
        hold     = 3'b000;
        d0 = '0;
        d1 = '0;
        d2 = '0;
        repeat (3) @(negedge clk);
        check(in_ready[0] == 1'b1, "rst_in_ready", in_ready[0], 1);
        check(active[0] == 1'b0, "rst_active", active[0], 0);
        check(tx_stb[0] == 1'b0, "rst_tx_stb", tx_stb[0], 0);
        check(txd[0] == 8'h00, "rst_tx_data", txd[0], 0);
        check(in_ready[1] == 1'b1, "rst_in_ready1", in_ready[1], 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push_str(0, "1234ABCD", 1);
        s = stbcnt[0];
        offer(0, 32'h1234ABCD, 0);
        bad = 0;
        n = 0;
        while (!(stbcnt[0] - s == 10 && busy_q[0]) && n < 1000) begin
            if (in_ready[0]) bad++;
            @(negedge clk);
            n++;
        end
        check(bad == 0, "ready_low_while_active", bad, 0);
        check(n < 1000, "lf_busy_timeout", n, 0);
        check(in_ready[0] == 1'b0, "ready_at_lf_busy", in_ready[0], 0);
        @(negedge clk);
        check(in_ready[0] == 1'b1, "ready_after_lf_busy", in_ready[0], 1);
        wait_idle(0);
        check(stbcnt[0] - s == 10, "stb_count_1234ABCD", stbcnt[0] - s, 10);

        push_str(0, "00000000", 1);
        push_str(0, "FFFFFFFF", 1);
        s = stbcnt[0];
        offer(0, 32'h00000000, 1);
        offer(0, 32'hFFFFFFFF, 0);
        check(qsize(0) == 10, "second_after_lf_queue", qsize(0), 10);
        check(stbcnt[0] - s == 10, "second_after_lf_stbs", stbcnt[0] - s, 10);
        wait_idle(0);
        check(stbcnt[0] - s == 20, "stb_count_b2b", stbcnt[0] - s, 20);

        push(1, 8'h39);
        push(1, 8'h41);
        s = stbcnt[1];
        offer(1, 32'h9A, 0);
        check(tx_stb[1] == 1'b0, "latency_cycle1", tx_stb[1], 0);
        @(posedge clk);
        #1;
        check(tx_stb[1] == 1'b1, "latency_cycle2_stb", tx_stb[1], 1);
        check(txd[1] == 8'h39, "latency_cycle2_data", txd[1], 8'h39);
        wait_idle(1);
        check(stbcnt[1] - s == 2, "stb_count_9A", stbcnt[1] - s, 2);

        @(negedge clk);
        hold[1] = 1'b1;
        push(1, 8'h39);
        push(1, 8'h41);
        s = stbcnt[1];
        offer(1, 32'h9A, 0);
        repeat (50) @(negedge clk);
        check(stbcnt[1] - s == 0, "no_stb_while_held", stbcnt[1] - s, 0);
        check(active[1] == 1'b1, "active_while_held", active[1], 1);
        hold[1] = 1'b0;
        wait_idle(1);
        check(stbcnt[1] - s == 2, "stb_count_held", stbcnt[1] - s, 2);

        push_str(0, "DEA", 0);
        s = stbcnt[0];
        offer(0, 32'hDEADBEEF, 0);
        wait_stbs(0, s, 3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check(tx_stb[0] == 1'b0, "midrst_tx_stb", tx_stb[0], 0);
        check(in_ready[0] == 1'b1, "midrst_in_ready", in_ready[0], 1);
        check(active[0] == 1'b0, "midrst_active", active[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_str(0, "00000005", 1);
        s = stbcnt[0];
        offer(0, 32'h5, 0);
        wait_idle(0);
        check(stbcnt[0] - s == 10, "stb_count_after_rst", stbcnt[0] - s, 10);

        push_str(2, "5", 1);
        s = stbcnt[2];
        offer(2, 32'h5, 0);
        wait_idle(2);
        check(stbcnt[2] - s == 3, "stb_count_w4", stbcnt[2] - s, 3);

        check(qsize(0) == 0, "sb_drained0", qsize(0), 0);
        check(qsize(1) == 0, "sb_drained1", qsize(1), 0);
        check(qsize(2) == 0, "sb_drained2", qsize(2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
